// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron: sums the weights of the inputs that spike,
// leaks the membrane potential, fires on a threshold crossing, then stays refractory.
module lif_post_neuron #(
  parameter int unsigned NUM_PRE    = 4,
  parameter int unsigned W_WIDTH    = 4,
  parameter int unsigned V_WIDTH    = 8,
  parameter int unsigned THRESHOLD  = 32,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRACT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  localparam int unsigned SYN_W = W_WIDTH + $clog2(NUM_PRE);
  localparam int unsigned VW1   = V_WIDTH + 1;
  localparam int unsigned RC_W  = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'((REFRACT > 0) ? REFRACT - 1 : 0);

  typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} state_t;

  state_t              state_q, state_d;
  logic [V_WIDTH-1:0]  mem_q, mem_d;
  logic                post_q, post_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;

  logic [SYN_W-1:0]    syn;
  logic [VW1-1:0]      v_sum;
  logic [V_WIDTH-1:0]  v_next;

  // pre_spike[i] is paired with the i-th weight counted from the MSB end of the bus
  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i]) begin
        syn = syn + SYN_W'(weight[NUM_PRE*W_WIDTH-1-W_WIDTH*i -: W_WIDTH]);
      end
    end
  end

  always_comb begin
    v_sum  = {1'b0, mem_q} - {1'b0, (mem_q >> LEAK_SHIFT)} + VW1'(syn);
    v_next = v_sum[V_WIDTH] ? '1 : v_sum[V_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    post_d  = 1'b0;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    if (en) begin
      unique case (state_q)
        ST_INTEGRATE: begin
          if (v_next >= V_WIDTH'(THRESHOLD)) begin
            mem_d   = '0;
            post_d  = 1'b1;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;
            state_d = (REFRACT == 0) ? ST_INTEGRATE : ST_REFRACTORY;
            rcnt_d  = RC_INIT;
          end else begin
            mem_d = v_next;
          end
        end
        ST_REFRACTORY: begin
          mem_d = '0;
          if (rcnt_q == '0) begin
            state_d = ST_INTEGRATE;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
        default: state_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INTEGRATE;
      mem_q   <= '0;
      post_q  <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign post_spike  = post_q;
  assign membrane    = mem_q;
  assign refractory  = (state_q == ST_REFRACTORY);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Bench for lif_post_neuron: directed vector table, hand-written corner sequences and
// random stimulus compared against an arithmetic model of the neuron.
module tb_lif_post_neuron;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  pre_spike = '0;
  logic [15:0] weight = '0;
  logic        post_spike;
  logic [7:0]  membrane;
  logic        refractory;
  logic [7:0]  spike_count;

  int n_checks = 0;
  int n_fail   = 0;

  lif_post_neuron #(
    .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8),
    .THRESHOLD(32), .LEAK_SHIFT(3), .REFRACT(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_spike), .membrane(membrane), .refractory(refractory),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  pre;
    logic [15:0] w;
    bit          post;
    int          mem;
    bit          refr;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit e, logic [3:0] p, logic [15:0] w,
                              bit po, int m, bit rf, int c);
    vec_t v;
    v.rst = r; v.en = e; v.pre = p; v.w = w;
    v.post = po; v.mem = m; v.refr = rf; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit po, input int m, input bit rf, input int c);
    chk({tag, ".post_spike"}, int'(post_spike), int'(po));
    chk({tag, ".membrane"}, int'(membrane), m);
    chk({tag, ".refractory"}, int'(refractory), int'(rf));
    chk({tag, ".spike_count"}, int'(spike_count), c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Reference model: refractory tracked as "edges of refractoriness still to serve"
  int m_v, m_cnt, m_refr;
  bit m_post;

  task automatic model_edge(input bit e, input logic [3:0] p, input logic [15:0] w);
    int syn, vn;
    if (!e) begin
      m_post = 0;
    end else if (m_refr > 0) begin
      m_refr--;
      m_v    = 0;
      m_post = 0;
    end else begin
      syn = 0;
      for (int i = 0; i < 4; i++)
        if (p[i]) syn += (w >> (12 - 4 * i)) & 15;
      vn = m_v - m_v / 8 + syn;
      if (vn > 255) vn = 255;
      if (vn >= 32) begin
        m_v    = 0;
        m_post = 1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_refr = 4;
      end else begin
        m_v    = vn;
        m_post = 0;
      end
    end
  endtask

  initial begin
    int fires;
    int mem_hold;

    // Directed table: accumulate, fire, refractory window, leak decay, full-weight fire
    vecs.push_back(mk(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 15, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 29, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 15, 0, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'hF000, 0, 29, 0, 1));
    begin
      int decay[15] = '{26, 23, 21, 19, 17, 15, 14, 13, 12, 11, 10, 9, 8, 7, 7};
      foreach (decay[k]) vecs.push_back(mk(0, 1, 4'h0, 16'hF000, 0, decay[k], 0, 1));
    end
    vecs.push_back(mk(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 16'hFFFF, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4'h2, 16'h0F00, 0, 0, 1, 1));

    #2;
    foreach (vecs[k]) begin
      if (vecs[k].rst) begin
        do_reset();
      end else begin
        en = vecs[k].en; pre_spike = vecs[k].pre; weight = vecs[k].w;
        step();
      end
      chk_all($sformatf("vec%0d", k), vecs[k].post, vecs[k].mem, vecs[k].refr, vecs[k].cnt);
    end

    // Async reset between edges, mid-refractory with a nonzero count
    en = 1; pre_spike = 4'hF; weight = 16'hFFFF;
    step();
    step();
    #1 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 0, 0);
    rst = 1'b0;

    // en=0 mid-integration freezes everything
    pre_spike = 4'h1; weight = 16'hF000;
    step();
    step();
    mem_hold = 29;
    en = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("freeze%0d", k), 0, mem_hold, 0, 0);
    end
    en = 1;
    step();
    chk_all("resume_fire", 1, 0, 1, 1);
    en = 0;
    step();
    chk_all("freeze_post", 0, 0, 1, 1);

    // Randomized stimulus against the model
    do_reset();
    m_v = 0; m_cnt = 0; m_refr = 0; m_post = 0;
    for (int k = 0; k < 600; k++) begin
      en        = ($urandom_range(0, 9) != 0);
      pre_spike = 4'($urandom);
      if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
      model_edge(en, pre_spike, weight);
      step();
      chk_all($sformatf("rand%0d", k), m_post, m_v, m_refr > 0, m_cnt);
    end

    // Drive 300+ fires and confirm the counter saturates
    do_reset();
    en = 1; pre_spike = 4'hF; weight = 16'hFFFF;
    fires = 0;
    for (int k = 0; k < 3000 && fires < 300; k++) begin
      step();
      if (post_spike) fires++;
    end
    chk("fire_budget", int'(fires >= 300), 1);
    chk("count_sat", int'(spike_count), 255);
    step();
    chk("count_sat_hold", int'(spike_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
